jk_bank_scheduler: RTL and testbench

//  Shares one bank of NUM_BITS JK-style flip-flop cells between NUM_REQ requesters.

---
 rtl/jk_bank_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/jk_bank_scheduler.sv | 150 +++++++++++++++
 tb/tb_jk_bank_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module : jk_bank_pkg
// Brief  : Shared op codes, FSM encoding and JK next-state helper for the
//          JK bank scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package jk_bank_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic logic jk_next(input logic q, input logic [1:0] op);
    logic n;
    unique case (op)
      OP_HOLD: n = q;
      OP_RST:  n = 1'b0;
      OP_SET:  n = 1'b1;
      default: n = ~q;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; first set request scanning
//          from ptr upward with wrap at NUM_REQ-1.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  int w_scan;

  // Wrap is a subtraction so non power-of-two requester counts work.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    w_scan = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan = int'(ptr) + i;
      if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
      if (!any && (w_scan < NUM_REQ) && req[w_scan]) begin
        any         = 1'b1;
        gnt[w_scan] = 1'b1;
        gnt_id      = ID_W'(w_scan);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jk_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module : jk_bank_scheduler
// Brief  : Round-robin scheduler sharing a bank of JK cells between
//          requesters, with a lock mode for back-to-back bursts.
// Rev    : 1.0  initial release
// ============================================================================
module jk_bank_scheduler
  import jk_bank_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 8,
  parameter int IDX_W    = $clog2(NUM_BITS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]   req_idx,
  input  logic [NUM_REQ*2-1:0]       req_op,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_BITS-1:0]        bank_q,
  output logic                       grant_vld,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       idx_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_owner;
  logic [NUM_BITS-1:0] r_bank;
  logic                r_grant_vld;
  logic [ID_W-1:0]     r_grant_id;
  logic                r_idx_err;

  logic [NUM_REQ-1:0]  w_owner_mask;
  logic [NUM_REQ-1:0]  w_arb_req;
  logic [ID_W-1:0]     w_arb_ptr;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_win_id;
  logic                w_any;
  logic                w_accept;
  logic                w_owner_valid;
  logic [IDX_W-1:0]    w_idx;
  logic [1:0]          w_op;
  logic                w_lock;
  logic                w_idx_ok;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  always_comb begin
    w_owner_mask = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      w_owner_mask[r] = (ID_W'(r) == r_owner);
    end
  end

  // While locked the arbiter only sees the owner, so the same grant path
  // serves both states.
  assign w_arb_req     = (r_state == ST_LOCKED) ? (req_valid & w_owner_mask) : req_valid;
  assign w_arb_ptr     = (r_state == ST_LOCKED) ? r_owner : r_ptr;
  assign w_owner_valid = |(req_valid & w_owner_mask);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (w_arb_req),
    .ptr    (w_arb_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_win_id),
    .any    (w_any)
  );

  assign req_ready = clr ? '0 : w_gnt;
  assign w_accept  = w_any & ~clr;

  always_comb begin
    w_idx  = '0;
    w_op   = OP_HOLD;
    w_lock = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (ID_W'(r) == w_win_id) begin
        w_idx  = req_idx[r*IDX_W +: IDX_W];
        w_op   = req_op[r*2 +: 2];
        w_lock = req_lock[r];
      end
    end
  end

  assign w_idx_ok = (int'(w_idx) < NUM_BITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ARB;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_bank      <= '0;
      r_grant_vld <= 1'b0;
      r_grant_id  <= '0;
      r_idx_err   <= 1'b0;
    end else if (clr) begin
      // Clear wipes the bank but leaves arbitration state where it was.
      r_bank      <= '0;
      r_grant_vld <= 1'b0;
      r_idx_err   <= 1'b0;
    end else begin
      r_grant_vld <= w_accept;
      r_idx_err   <= w_accept & ~w_idx_ok;
      if (w_accept) r_grant_id <= w_win_id;
      for (int b = 0; b < NUM_BITS; b++) begin
        if (w_accept && w_idx_ok && (int'(w_idx) == b)) begin
          r_bank[b] <= jk_next(r_bank[b], w_op);
        end
      end
      case (r_state)
        ST_ARB: begin
          if (w_accept) begin
            r_ptr <= next_id(w_win_id);
            if (w_lock) begin
              r_state <= ST_LOCKED;
              r_owner <= w_win_id;
            end
          end
        end
        ST_LOCKED: begin
          if (!w_owner_valid) begin
            r_state <= ST_ARB;
          end else if (w_accept && !w_lock) begin
            r_state <= ST_ARB;
            r_ptr   <= next_id(r_owner);
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign bank_q    = r_bank;
  assign grant_vld = r_grant_vld;
  assign grant_id  = r_grant_id;
  assign idx_err   = r_idx_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_jk_bank_scheduler
// Brief  : Directed bench with a scoreboard queue for jk_bank_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
module tb_jk_bank_scheduler;
  import jk_bank_pkg::*;

  localparam int NR = 4;
  localparam int IW = 3;

  typedef struct packed {
    logic [1:0] id;
    logic       err;
    logic [7:0] bank;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clr;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*IW-1:0] req_idx;
  logic [NR*2-1:0] req_op;
  logic [NR-1:0]   req_lock;
  logic [7:0]      bank_q;
  logic            grant_vld;
  logic [1:0]      grant_id;
  logic            idx_err;

  logic            d6_clr;
  logic [NR-1:0]   d6_valid;
  logic [NR-1:0]   d6_ready;
  logic [NR*IW-1:0] d6_idx;
  logic [NR*2-1:0] d6_op;
  logic [NR-1:0]   d6_lock;
  logic [5:0]      d6_bank;
  logic            d6_gvld;
  logic [1:0]      d6_gid;
  logic            d6_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  jk_bank_scheduler #(.NUM_REQ(4), .NUM_BITS(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_idx(req_idx), .req_op(req_op), .req_lock(req_lock), .bank_q(bank_q),
    .grant_vld(grant_vld), .grant_id(grant_id), .idx_err(idx_err)
  );

  jk_bank_scheduler #(.NUM_REQ(4), .NUM_BITS(6), .IDX_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .clr(d6_clr), .req_valid(d6_valid), .req_ready(d6_ready),
    .req_idx(d6_idx), .req_op(d6_op), .req_lock(d6_lock), .bank_q(d6_bank),
    .grant_vld(d6_gvld), .grant_id(d6_gid), .idx_err(d6_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic err, input logic [7:0] bank);
    exp_t e;
    e.id   = id;
    e.err  = err;
    e.bank = bank;
    sb.push_back(e);
  endtask

  task automatic set_req(input int r, input logic [2:0] idx, input logic [1:0] op, input logic lock);
    req_valid[r]        = 1'b1;
    req_idx[r*IW +: IW] = idx;
    req_op[r*2 +: 2]    = op;
    req_lock[r]         = lock;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ready_is(input string name, input logic [3:0] exp);
    @(negedge clk);
    chk(name, req_ready, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    clr       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every registered grant must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && grant_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got id %0d bank %0h expected no grant", grant_id, bank_q);
      end else begin
        e = sb.pop_front();
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("idx_err",  32'(idx_err),  32'(e.err));
        chk("bank_q",   32'(bank_q),   32'(e.bank));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    req_valid = '0; req_idx = '0; req_op = '0; req_lock = '0;
    d6_clr = 1'b0; d6_valid = '0; d6_idx = '0; d6_op = '0; d6_lock = '0;

    // 1: reset state, then first op
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bank", 32'(bank_q), 32'h0);
    chk("rst_gvld", 32'(grant_vld), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    set_req(0, 3'd3, OP_SET, 1'b0);
    push(2'd0, 1'b0, 8'h08);
    tick();
    req_valid = '0;

    // 2: round robin from ptr 0
    do_reset();
    for (int r = 0; r < NR; r++) set_req(r, 3'(r), OP_SET, 1'b0);
    push(2'd0, 1'b0, 8'h01);
    push(2'd1, 1'b0, 8'h03);
    push(2'd2, 1'b0, 8'h07);
    push(2'd3, 1'b0, 8'h0F);
    push(2'd0, 1'b0, 8'h0F);
    ready_is("rr_ready0", 4'b0001);
    repeat (5) tick();
    req_valid = '0;

    // 3: op sequence on idx5
    do_reset();
    set_req(2, 3'd5, OP_SET, 1'b0);
    push(2'd2, 1'b0, 8'h20);
    push(2'd2, 1'b0, 8'h00);
    push(2'd2, 1'b0, 8'h20);
    push(2'd2, 1'b0, 8'h00);
    push(2'd2, 1'b0, 8'h00);
    tick();
    req_op[5:4] = OP_TGL;
    tick();
    tick();
    req_op[5:4] = OP_RST;
    tick();
    req_op[5:4] = OP_HOLD;
    tick();
    req_valid = '0;

    // 4: lock burst by req1 after moving ptr to 1
    do_reset();
    set_req(0, 3'd0, OP_HOLD, 1'b0);
    push(2'd0, 1'b0, 8'h00);
    tick();
    req_valid = '0;
    set_req(1, 3'd1, OP_SET, 1'b1);
    set_req(0, 3'd0, OP_SET, 1'b0);
    set_req(3, 3'd6, OP_SET, 1'b0);
    push(2'd1, 1'b0, 8'h02);
    push(2'd1, 1'b0, 8'h06);
    push(2'd1, 1'b0, 8'h16);
    push(2'd3, 1'b0, 8'h56);
    push(2'd0, 1'b0, 8'h57);
    ready_is("lock_first", 4'b0010);
    tick();
    set_req(1, 3'd2, OP_SET, 1'b1);
    ready_is("lock_stall", 4'b0010);
    tick();
    set_req(1, 3'd4, OP_SET, 1'b0);
    tick();
    req_valid[1] = 1'b0;
    ready_is("unlock_next", 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    // owner drops valid mid-burst
    set_req(1, 3'd0, OP_TGL, 1'b1);
    set_req(2, 3'd3, OP_SET, 1'b0);
    push(2'd1, 1'b0, 8'h56);
    push(2'd2, 1'b0, 8'h5E);
    tick();
    req_valid[1] = 1'b0;
    ready_is("drop_stall", 4'b0000);
    tick();
    ready_is("drop_rearb", 4'b0100);
    tick();
    req_valid[2] = 1'b0;

    // 5: synchronous clear
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_req(0, 3'(i), OP_SET, 1'b0);
      push(2'd0, 1'b0, 8'((16'h1 << (i + 1)) - 16'h1));
      tick();
    end
    set_req(0, 3'd2, OP_SET, 1'b0);
    clr = 1'b1;
    ready_is("clr_ready", 4'b0000);
    tick();
    chk("clr_bank", 32'(bank_q), 32'h0);
    chk("clr_gvld", 32'(grant_vld), 32'h0);
    clr = 1'b0;
    push(2'd0, 1'b0, 8'h04);
    ready_is("post_clr_ready", 4'b0001);
    tick();
    req_valid = '0;

    // 6: async reset while locked
    do_reset();
    set_req(0, 3'd0, OP_SET, 1'b0); push(2'd0, 1'b0, 8'h01); tick();
    set_req(0, 3'd2, OP_SET, 1'b0); push(2'd0, 1'b0, 8'h05); tick();
    set_req(0, 3'd5, OP_SET, 1'b0); push(2'd0, 1'b0, 8'h25); tick();
    set_req(0, 3'd7, OP_SET, 1'b0); push(2'd0, 1'b0, 8'hA5); tick();
    req_valid = '0;
    set_req(1, 3'd0, OP_HOLD, 1'b1);
    push(2'd1, 1'b0, 8'hA5);
    tick();
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("arst_bank", 32'(bank_q), 32'h0);
    chk("arst_gvld", 32'(grant_vld), 32'h0);
    chk("arst_gid", 32'(grant_id), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < NR; r++) set_req(r, 3'd0, OP_HOLD, 1'b0);
    push(2'd0, 1'b0, 8'h00);
    ready_is("arst_rearb", 4'b0001);
    tick();
    req_valid = '0;

    // out-of-range index on a 6-cell bank
    d6_valid = 4'b0001; d6_idx[2:0] = 3'd7; d6_op[1:0] = OP_SET;
    tick();
    d6_valid = '0;
    chk("d6_gvld", 32'(d6_gvld), 32'h1);
    chk("d6_err", 32'(d6_err), 32'h1);
    chk("d6_bank", 32'(d6_bank), 32'h0);
    tick();
    chk("d6_err_pulse", 32'(d6_err), 32'h0);
    d6_valid = 4'b0001; d6_idx[2:0] = 3'd5;
    tick();
    d6_valid = '0;
    chk("d6_bank5", 32'(d6_bank), 32'h20);
    chk("d6_err_ok", 32'(d6_err), 32'h0);

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
